// File: rtl/reg_write_arb_if.sv
// Shared write-port bundle: requesters drive req/data/lock,
// the arbiter returns the one-hot grant and the bank load strobe.
interface reg_write_arb_if #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 16
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] data;
    logic [NUM_REQ-1:0]       lock;
    logic [NUM_REQ-1:0]       gnt;
    logic [WIDTH-1:0]         reg_d;
    logic                     reg_load;
    logic                     contend;

    modport master (
        output req, data, lock,
        input  gnt, reg_d, reg_load, contend
    );

    modport slave (
        input  req, data, lock,
        output gnt, reg_d, reg_load, contend
    );
endinterface

// File: rtl/reg_write_arb.sv
// Round-robin arbiter for one register-bank write port.
// Define REG_ARB_LOCK_EN to enable bounded burst locking.
module reg_write_arb #(
    parameter int NUM_REQ  = 2,
    parameter int WIDTH    = 16,
    parameter int LOCK_MAX = 8
) (
    input logic            clk,
    input logic            rst,
    reg_write_arb_if.slave bus
);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [PW-1:0]        ptr;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [WIDTH-1:0]     d_q;
    logic                 contend_q;

    logic [WIDTH-1:0]     dw [NUM_REQ];
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic                 arb_hit;
    logic [PW-1:0]        arb_idx;

    logic                 sel_hold;
    logic                 sel_lock;
    logic                 sel_grant;
    logic                 lock_ok;
    logic [PW-1:0]        hold_id;

    logic [NUM_REQ-1:0]   gnt_nx;
    logic [WIDTH-1:0]     d_nx;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
        assign dw[g] = bus.data[g*WIDTH +: WIDTH];
    end

    // Rotate so bit 0 is the requester at ptr, then find first set.
    assign req_dbl = {bus.req, bus.req};
    assign req_rot = NUM_REQ'(req_dbl >> ptr);

    always_comb begin
        logic [PW-1:0] off;
        logic [PW:0]   sum;
        arb_hit = 1'b0;
        off     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                arb_hit = 1'b1;
                off     = PW'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (PW+1)'(NUM_REQ)) begin
            sum = sum - (PW+1)'(NUM_REQ);
        end
        arb_idx = sum[PW-1:0];
    end

`ifdef REG_ARB_LOCK_EN
    logic [3:0]    lock_cnt;
    logic [PW-1:0] lock_id;
    logic          blk_vld;
    logic [PW-1:0] blk_id;
    logic          forced;
    logic          cand_vld;
    logic [PW-1:0] cand_id;

    assign forced   = (state == LOCKED) && (lock_cnt == 4'(LOCK_MAX));
    assign sel_hold = (state == LOCKED) && !forced
                      && bus.req[lock_id] && bus.lock[lock_id];
    // A burst that hit the cap may not re-lock until it loses or skips.
    assign cand_vld = forced || blk_vld;
    assign cand_id  = forced ? lock_id : blk_id;
    assign lock_ok  = bus.lock[arb_idx]
                      && !(cand_vld && (cand_id == arb_idx));
    assign hold_id  = lock_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt <= '0;
            lock_id  <= '0;
            blk_vld  <= 1'b0;
            blk_id   <= '0;
        end else begin
            if (sel_hold) begin
                lock_cnt <= lock_cnt + 4'd1;
            end else if (sel_lock) begin
                lock_cnt <= 4'd1;
                lock_id  <= arb_idx;
            end else begin
                lock_cnt <= '0;
            end
            if (!sel_hold) begin
                blk_vld <= cand_vld && arb_hit && (cand_id == arb_idx);
                blk_id  <= cand_id;
            end
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^bus.lock;
    assign sel_hold    = 1'b0;
    assign lock_ok     = 1'b0;
    assign hold_id     = '0;
`endif

    assign sel_lock  = !sel_hold && arb_hit && lock_ok;
    assign sel_grant = !sel_hold && arb_hit && !lock_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_q     <= '0;
            d_q       <= '0;
            contend_q <= 1'b0;
        end else begin
            state     <= state_nx;
            gnt_q     <= gnt_nx;
            d_q       <= d_nx;
            contend_q <= ($countones(bus.req) > 1);
            if (!sel_hold && arb_hit) begin
                ptr <= inc(arb_idx);
            end
        end
    end

    always_comb begin
        state_nx = IDLE;
        unique case (1'b1)
            sel_hold:  state_nx = LOCKED;
            sel_lock:  state_nx = LOCKED;
            sel_grant: state_nx = GRANT;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        gnt_nx = '0;
        d_nx   = d_q;
        if (sel_hold) begin
            gnt_nx[hold_id] = 1'b1;
            d_nx            = dw[hold_id];
        end else if (arb_hit) begin
            gnt_nx[arb_idx] = 1'b1;
            d_nx            = dw[arb_idx];
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.reg_d    = d_q;
    assign bus.reg_load = (state != IDLE);
    assign bus.contend  = contend_q;
endmodule

// File: tb/tb_reg_write_arb.sv
// Randomised bench for reg_write_arb (2- and 4-requester instances)
// against a rule-level model, plus hand-computed directed cases.
module tb_reg_write_arb;
`ifdef REG_ARB_LOCK_EN
    localparam bit LK = 1'b1;
`else
    localparam bit LK = 1'b0;
`endif
    localparam int LMAX = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_write_arb_if #(.NUM_REQ(2), .WIDTH(16)) b2 ();
    reg_write_arb_if #(.NUM_REQ(4), .WIDTH(16)) b4 ();

    reg_write_arb #(.NUM_REQ(2), .WIDTH(16), .LOCK_MAX(LMAX)) u2 (
        .clk(clk), .rst(rst), .bus(b2)
    );
    reg_write_arb #(.NUM_REQ(4), .WIDTH(16), .LOCK_MAX(LMAX)) u4 (
        .clk(clk), .rst(rst), .bus(b4)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    typedef struct {
        int         ptr;
        bit         locked;
        int         lid;
        int         cnt;
        bit         blk;
        int         bid;
        logic [3:0] gnt;
        logic [15:0] d;
        bit         con;
    } m_t;

    m_t m2, m4;

    function automatic m_t mreset();
        m_t m;
        m.ptr = 0; m.locked = 0; m.lid = 0; m.cnt = 0;
        m.blk = 0; m.bid = 0; m.gnt = '0; m.d = '0; m.con = 0;
        return m;
    endfunction

    function automatic void step(inout m_t m, input int n,
                                 input logic [3:0] rq,
                                 input logic [63:0] dt,
                                 input logic [3:0] lk);
        int  base, w, bid;
        bit  forced, bv;
        m.con = ($countones(rq) >= 2);
        m.gnt = '0;
        if (LK && m.locked && m.cnt < LMAX && rq[m.lid] && lk[m.lid]) begin
            m.gnt[m.lid] = 1'b1;
            m.d = dt[m.lid*16 +: 16];
            m.cnt++;
            return;
        end
        forced = LK && m.locked && (m.cnt >= LMAX);
        base = m.locked ? (m.lid + 1) % n : m.ptr;
        bv  = forced ? 1'b1 : m.blk;
        bid = forced ? m.lid : m.bid;
        m.locked = 0;
        m.cnt = 0;
        m.ptr = base;
        w = -1;
        for (int k = 0; k < n; k++) begin
            if (w < 0 && rq[(base + k) % n]) w = (base + k) % n;
        end
        if (w < 0) begin
            m.blk = 0;
            return;
        end
        m.gnt[w] = 1'b1;
        m.d = dt[w*16 +: 16];
        m.ptr = (w + 1) % n;
        m.blk = bv && (bid == w);
        m.bid = bid;
        if (LK && lk[w] && !(bv && bid == w)) begin
            m.locked = 1;
            m.lid = w;
            m.cnt = 1;
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m2 = mreset();
            m4 = mreset();
        end else begin
            step(m2, 2, {2'b00, b2.req}, {32'h0, b2.data}, {2'b00, b2.lock});
            step(m4, 4, b4.req, b4.data, b4.lock);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("gnt2", 64'(b2.gnt), 64'(m2.gnt[1:0]));
            chk("d2", 64'(b2.reg_d), 64'(m2.d));
            chk("load2", 64'(b2.reg_load), 64'(|m2.gnt));
            chk("con2", 64'(b2.contend), 64'(m2.con));
            chk("gnt4", 64'(b4.gnt), 64'(m4.gnt));
            chk("d4", 64'(b4.reg_d), 64'(m4.d));
            chk("load4", 64'(b4.reg_load), 64'(|m4.gnt));
            chk("con4", 64'(b4.contend), 64'(m4.con));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [3:0] rbits();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 9) < 6);
        return r;
    endfunction

    initial begin
        logic [3:0] r;
        logic [1:0] e;
        b2.req = '0; b2.lock = '0; b2.data = '0;
        b4.req = '0; b4.lock = '0; b4.data = '0;
        rst = 1'b1;
        tick();
        tick();
        chk_en = 1'b1;
        rst = 1'b0;

        repeat (3) begin
            tick();
            chk("idle_gnt", 64'(b2.gnt), 64'h0);
            chk("idle_load", 64'(b2.reg_load), 64'h0);
            chk("idle_d", 64'(b2.reg_d), 64'h0);
            chk("idle_con", 64'(b2.contend), 64'h0);
        end

        b2.req = 2'b01;
        b2.data = {16'h0000, 16'hA5A5};
        tick();
        b2.req = 2'b00;
        chk("single_gnt", 64'(b2.gnt), 64'h1);
        chk("single_load", 64'(b2.reg_load), 64'h1);
        chk("single_d", 64'(b2.reg_d), 64'hA5A5);
        chk("model_single", 64'(m2.d), 64'hA5A5);
        tick();
        chk("single_drop", 64'(b2.reg_load), 64'h0);

        do_reset();
        b2.req = 2'b11;
        b2.data = {16'h2222, 16'h1111};
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_gnt", 64'(b2.gnt), (i % 2 == 0) ? 64'h1 : 64'h2);
            chk("rr_d", 64'(b2.reg_d), (i % 2 == 0) ? 64'h1111 : 64'h2222);
            chk("rr_con", 64'(b2.contend), 64'h1);
        end
        b2.req = 2'b00;

        do_reset();
        b4.req = 4'b0100;
        tick();
        chk("pre_wrap", 64'(b4.gnt), 64'h4);
        b4.req = 4'b1001;
        tick();
        chk("wrap_gnt", 64'(b4.gnt), 64'h8);
        chk("model_wrap", 64'(m4.gnt), 64'h8);
        tick();
        chk("wrap_ptr0", 64'(b4.gnt), 64'h1);
        b4.req = 4'b0000;

        do_reset();
        b2.req = 2'b11;
        b2.lock = 2'b01;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (LK) e = (i == 8) ? 2'b10 : 2'b01;
            else e = (i % 2 == 0) ? 2'b01 : 2'b10;
            chk("lock_gnt", 64'(b2.gnt), 64'(e));
        end

        do_reset();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rst_gnt", 64'(b2.gnt), 64'h0);
        chk("rst_load", 64'(b2.reg_load), 64'h0);
        chk("rst_d", 64'(b2.reg_d), 64'h0);
        chk("rst_con", 64'(b2.contend), 64'h0);
        rst = 1'b0;
        b2.req = 2'b10;
        b2.lock = 2'b00;
        tick();
        chk("post_rst_gnt", 64'(b2.gnt), 64'h2);

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 1) == 1) begin
                r = rbits();
                b2.req = r[1:0];
                r = rbits();
                b2.lock = r[1:0];
            end
            if ($urandom_range(0, 1) == 1) begin
                b4.req = rbits();
                b4.lock = rbits();
            end
            b2.data = $urandom;
            b4.data = {$urandom, $urandom};
            tick();
        end
        rst = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
